// File: rtl/usr_shift_sequencer.sv
// usr_shift_sequencer: expands one command per valid/ready handshake into a
// timed control sequence (s, in, msb, lsb) for a universal shift register.
// Commands: NOP, LOAD, SHR, SHL, ROTR, ROTL. Rotates feed the register output
// back as the serial input, and done pulses for one cycle at completion.
// Optional build macro USR_SEQ_ABORT_EN adds an abort input and an aborted
// flag that cuts a running shift/rotate short.
module usr_shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] usr_q,
`ifdef USR_SEQ_ABORT_EN
  input  logic             abort,
  output logic             aborted,
`endif
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_in,
  output logic             usr_msb,
  output logic             usr_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_SHR  = 3'b010;
  localparam logic [2:0] OP_SHL  = 3'b011;
  localparam logic [2:0] OP_ROTR = 3'b100;
  localparam logic [2:0] OP_ROTL = 3'b101;

  localparam logic [1:0] S_HOLD  = 2'b00;
  localparam logic [1:0] S_RIGHT = 2'b01;
  localparam logic [1:0] S_LEFT  = 2'b10;
  localparam logic [1:0] S_LOAD  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [2:0]       op_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       s_r;
  logic [WIDTH-1:0] in_r;
  logic             msb_r;
  logic             lsb_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;
  logic             stop_s;
  logic             abort_hit_s;
  logic             rotr_active_s;
  logic             rotl_active_s;
  logic             unused_q_s;

`ifdef USR_SEQ_ABORT_EN
  logic aborted_r;
  assign abort_hit_s = abort;
  assign aborted     = aborted_r;
`else
  assign abort_hit_s = 1'b0;
`endif

  // Only the end bits of the feedback bus drive rotates; keep the rest referenced.
  assign unused_q_s = ^usr_q;

  assign cmd_ready = (state_r == ST_IDLE);
  assign accept_s  = cmd_valid & cmd_ready;
  assign stop_s    = (cnt_r == CNT_ONE) | abort_hit_s;

  assign usr_s  = s_r;
  assign usr_in = in_r;
  assign busy   = busy_r;
  assign done   = done_r;

  // Rotate serial inputs follow the live register value during active rotate steps.
  always_comb begin
    rotr_active_s = (state_r == ST_RUN) && (op_r == OP_ROTR);
    rotl_active_s = (state_r == ST_RUN) && (op_r == OP_ROTL);
    if (rotr_active_s) begin
      usr_msb = usr_q[0];
    end else begin
      usr_msb = msb_r;
    end
    if (rotl_active_s) begin
      usr_lsb = usr_q[WIDTH-1];
    end else begin
      usr_lsb = lsb_r;
    end
  end

  // Sequencer FSM: accept, step through active cycles, pulse done, return to idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      op_r    <= 3'b000;
      cnt_r   <= CNT_ZERO;
      s_r     <= S_HOLD;
      in_r    <= {WIDTH{1'b0}};
      msb_r   <= 1'b0;
      lsb_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
      aborted_r <= 1'b0;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
          aborted_r <= 1'b0;
`endif
          if (accept_s) begin
            op_r   <= cmd_op;
            cnt_r  <= cmd_count;
            busy_r <= 1'b1;
            case (cmd_op)
              OP_LOAD: begin
                cnt_r   <= CNT_ONE;
                in_r    <= cmd_data;
                s_r     <= S_LOAD;
                state_r <= ST_RUN;
              end
              OP_SHR, OP_SHL, OP_ROTR, OP_ROTL: begin
                if (cmd_count == CNT_ZERO) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                end else begin
                  state_r <= ST_RUN;
                  if (cmd_op == OP_SHR) begin
                    s_r   <= S_RIGHT;
                    msb_r <= cmd_fill;
                  end else if (cmd_op == OP_SHL) begin
                    s_r   <= S_LEFT;
                    lsb_r <= cmd_fill;
                  end else if (cmd_op == OP_ROTR) begin
                    s_r <= S_RIGHT;
                  end else begin
                    s_r <= S_LEFT;
                  end
                end
              end
              default: begin
                state_r <= ST_DONE;
                done_r  <= 1'b1;
              end
            endcase
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_RUN: begin
          // Capture the rotate feedback so it holds once the step ends.
          if (op_r == OP_ROTR) begin
            msb_r <= usr_q[0];
          end else if (op_r == OP_ROTL) begin
            lsb_r <= usr_q[WIDTH-1];
          end else begin
            msb_r <= msb_r;
          end
          cnt_r <= cnt_r - CNT_ONE;
          if (stop_s) begin
            state_r <= ST_DONE;
            s_r     <= S_HOLD;
            done_r  <= 1'b1;
`ifdef USR_SEQ_ABORT_EN
            aborted_r <= abort;
`endif
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
`ifdef USR_SEQ_ABORT_EN
          aborted_r <= 1'b0;
`endif
        end
        default: begin
          state_r <= ST_IDLE;
          s_r     <= S_HOLD;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usr_shift_sequencer.sv
// Bench for usr_shift_sequencer: drives directed commands into the sequencer,
// closes the loop through a universal shift register model, and checks every
// cycle against an expectation queue built from the command-level rules.
module tb_usr_shift_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [3:0] cmd_data;
  logic [2:0] cmd_count;
  logic       cmd_fill;
  logic [3:0] usr_q;
  logic [1:0] usr_s;
  logic [3:0] usr_in;
  logic       usr_msb;
  logic       usr_lsb;
  logic       busy;
  logic       done;
`ifdef USR_SEQ_ABORT_EN
  logic       abort;
  logic       aborted;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit run_chk  = 1'b0;
  logic [3:0] mv;  // model of the register content

  typedef struct packed {
    logic [1:0] s;
    logic       busy;
    logic       done;
    logic       ready;
    logic       abt;
    logic [3:0] qv;
    logic       chk_in;
    logic [3:0] din;
    logic       chk_msb;
    logic       msb;
    logic       chk_lsb;
    logic       lsb;
  } exp_t;

  exp_t q_exp[$];

  usr_shift_sequencer #(.WIDTH(4), .CNT_W(3)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .cmd_fill(cmd_fill), .usr_q(usr_q),
`ifdef USR_SEQ_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .usr_s(usr_s), .usr_in(usr_in), .usr_msb(usr_msb), .usr_lsb(usr_lsb),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Universal shift register the sequencer controls.
  always @(posedge clk) begin
    if (reset) usr_q <= 4'b0000;
    else begin
      case (usr_s)
        2'b01:   usr_q <= {usr_msb, usr_q[3:1]};
        2'b10:   usr_q <= {usr_q[2:0], usr_lsb};
        2'b11:   usr_q <= usr_in;
        default: usr_q <= usr_q;
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Build per-cycle expectations for one accepted command and advance the model.
  task automatic model_cmd(input logic [2:0] op, input logic [3:0] data,
                           input logic [2:0] cnt, input logic fill);
    int n;
    int v;
    logic [1:0] code;
    exp_t e;
    n = 0;
    code = 2'b00;
    case (op)
      3'b001:  begin n = 1;   code = 2'b11; end
      3'b010:  begin n = cnt; code = 2'b01; end
      3'b011:  begin n = cnt; code = 2'b10; end
      3'b100:  begin n = cnt; code = 2'b01; end
      3'b101:  begin n = cnt; code = 2'b10; end
      default: begin n = 0;   code = 2'b00; end
    endcase
    for (int i = 0; i < n; i++) begin
      e = '0;
      e.s = code;
      e.busy = 1'b1;
      e.qv = mv;
      v = int'(mv);
      case (op)
        3'b001: begin e.chk_in = 1'b1; e.din = data; v = int'(data); end
        3'b010: begin e.chk_msb = 1'b1; e.msb = fill; v = (v >> 1) | (int'(fill) << 3); end
        3'b011: begin e.chk_lsb = 1'b1; e.lsb = fill; v = ((v << 1) & 15) | int'(fill); end
        3'b100: begin e.chk_msb = 1'b1; e.msb = mv[0]; v = (v >> 1) | ((v & 1) << 3); end
        default: begin e.chk_lsb = 1'b1; e.lsb = mv[3]; v = ((v << 1) | (v >> 3)) & 15; end
      endcase
      mv = v[3:0];
      q_exp.push_back(e);
    end
    e = '0;
    e.busy = 1'b1;
    e.done = 1'b1;
    e.qv = mv;
    q_exp.push_back(e);
  endtask

  // Per-cycle comparison of all DUT outputs against the expectation queue.
  always @(negedge clk) begin : cmp
    exp_t e;
    if (run_chk && !reset) begin
      if (q_exp.size() > 0) e = q_exp.pop_front();
      else begin
        e = '0;
        e.ready = 1'b1;
        e.qv = mv;
      end
      chk("usr_s", usr_s, e.s);
      chk("busy", busy, e.busy);
      chk("done", done, e.done);
      chk("cmd_ready", cmd_ready, e.ready);
      chk("usr_q", usr_q, e.qv);
      if (e.chk_in) chk("usr_in", usr_in, e.din);
      if (e.chk_msb) chk("usr_msb", usr_msb, e.msb);
      if (e.chk_lsb) chk("usr_lsb", usr_lsb, e.lsb);
`ifdef USR_SEQ_ABORT_EN
      chk("aborted", aborted, e.abt);
`endif
    end
  end

  // Present a command until accepted, then scramble the fields while busy.
  task automatic do_cmd(input logic [2:0] op, input logic [3:0] data,
                        input logic [2:0] cnt, input logic fill);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    cmd_op = op; cmd_data = data; cmd_count = cnt; cmd_fill = fill;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    model_cmd(op, data, cnt, fill);
    cmd_op = 3'b001; cmd_data = ~data; cmd_count = ~cnt; cmd_fill = ~fill;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (q_exp.size() > 0 && guard < 40) begin
      @(negedge clk); #1;
      guard++;
    end
    if (q_exp.size() > 0) begin
      chk("done_timeout", q_exp.size(), 0);
      q_exp.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] mv0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'b000; cmd_data = 4'b0000;
    cmd_count = 3'b000; cmd_fill = 1'b0; mv = 4'b0000;
`ifdef USR_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_usr_s", usr_s, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_q", usr_q, 0);
    chk("rst_in", usr_in, 0);
    chk("rst_msb", usr_msb, 0);
    chk("rst_lsb", usr_lsb, 0);
    reset = 1'b0;
    run_chk = 1'b1;

    do_cmd(3'b001, 4'b1010, 3'd0, 1'b0); wait_idle();
    chk("load_1010", usr_q, 4'b1010);

    do_cmd(3'b001, 4'b0000, 3'd0, 1'b0); wait_idle();
    do_cmd(3'b010, 4'b0000, 3'd3, 1'b1); wait_idle();
    chk("shr3_fill1", usr_q, 4'b1110);

    do_cmd(3'b001, 4'b1001, 3'd0, 1'b0); wait_idle();
    do_cmd(3'b101, 4'b0000, 3'd1, 1'b0); wait_idle();
    chk("rotl1", usr_q, 4'b0011);
    do_cmd(3'b100, 4'b0000, 3'd4, 1'b0); wait_idle();
    chk("rotr4", usr_q, 4'b0011);
    do_cmd(3'b100, 4'b0000, 3'd1, 1'b0); wait_idle();
    chk("rotr1", usr_q, 4'b1001);

    do_cmd(3'b011, 4'b0000, 3'd0, 1'b1); wait_idle();
    chk("shl0_unchanged", usr_q, 4'b1001);
    do_cmd(3'b111, 4'b0110, 3'd5, 1'b1); wait_idle();
    chk("op111_unchanged", usr_q, 4'b1001);
    do_cmd(3'b000, 4'b0110, 3'd2, 1'b1); wait_idle();
    do_cmd(3'b011, 4'b0000, 3'd2, 1'b1); wait_idle();
    chk("shl2_fill1", usr_q, 4'b0111);

    // Reset in the third active cycle of a 7-step shift left.
    do_cmd(3'b011, 4'b0000, 3'd7, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    q_exp.delete();
    mv = 4'b0000;
    chk("midrst_usr_s", usr_s, 0);
    chk("midrst_done", done, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ready", cmd_ready, 1);
    repeat (3) @(posedge clk);
    #1;

`ifdef USR_SEQ_ABORT_EN
    do_cmd(3'b001, 4'b1111, 3'd0, 1'b0); wait_idle();
    mv0 = mv;
    do_cmd(3'b011, 4'b0000, 3'd7, 1'b0);
    abort = 1'b1;
    begin
      exp_t e2;
      exp_t ed;
      e2 = q_exp[0];
      q_exp.delete();
      q_exp.push_back(e2);
      mv = (mv0 << 2) & 4'b1111;
      ed = '0;
      ed.busy = 1'b1;
      ed.done = 1'b1;
      ed.abt = 1'b1;
      ed.qv = mv;
      q_exp.push_back(ed);
    end
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_flag", aborted, 1);
    wait_idle();
    chk("abort_q", usr_q, 4'b1100);
    // abort outside RUN has no effect
    abort = 1'b1;
    do_cmd(3'b000, 4'b0000, 3'd0, 1'b0); wait_idle();
    abort = 1'b0;
`endif

    do_cmd(3'b001, 4'b0101, 3'd0, 1'b0); wait_idle();
    chk("final_load", usr_q, 4'b0101);
    repeat (2) @(posedge clk);
    run_chk = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
